// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART TX arbiter: FSM state encoding and
// default parameter values used by the interface, the picker and the top level.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } arb_state_e;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_GAP_CYCLES = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side request bus plus the transmitter load/start/done handshake.
// master = the arbiter, slave = producers and transmitter seen as one peer.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*DATA_W-1:0]   req_data;
  logic [N_REQ-1:0]          req_ready;
  logic                      tx_load;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_start;
  logic                      tx_done;
  logic [$clog2(N_REQ)-1:0]  grant_id;
  logic                      busy;

  modport master (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_load, tx_data, tx_start, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_load, tx_data, tx_start, grant_id, busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker: first set request searching upward
// from last+1 (mod N), wrapping around so last itself has lowest priority.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    gnt_onehot,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  int w_cand;

  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    w_cand  = 0;
    for (int k = 1; k <= N; k++) begin
      w_cand = (int'(last) + k) % N;
      if (!any && req[w_cand]) begin
        any     = 1'b1;
        gnt_idx = ID_W'(w_cand);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign gnt_onehot[gi] = any && (gnt_idx == ID_W'(gi));
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte producers: round-robin accept,
// then LOAD/START pulses, wait for tx_done, optional idle gap between frames.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.master  bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  arb_state_e          r_state;
  logic [ID_W-1:0]     r_last;
  logic [ID_W-1:0]     r_grant_id;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_tx_load;
  logic                r_tx_start;
  logic                r_busy;
  logic [GAP_W-1:0]    r_gap_cnt;

  logic [N_REQ-1:0]    w_gnt_onehot;
  logic [ID_W-1:0]     w_gnt_idx;
  logic                w_any;
  logic [DATA_W-1:0]   w_req_bytes [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_req_bytes[gi] = bus.req_data[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req        (bus.req_valid),
    .last       (r_last),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  // Reset also masks the accept so nothing can be handed over while held.
  assign bus.req_ready = (r_state == IDLE && !reset) ? w_gnt_onehot : '0;
  assign bus.tx_load   = r_tx_load;
  assign bus.tx_start  = r_tx_start;
  assign bus.tx_data   = r_tx_data;
  assign bus.grant_id  = r_grant_id;
  assign bus.busy      = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= ID_W'(N_REQ - 1);
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_tx_load  <= 1'b0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_gap_cnt  <= '0;
    end else begin
      r_tx_load  <= 1'b0;
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state    <= LOAD;
            r_tx_load  <= 1'b1;
            r_tx_data  <= w_req_bytes[w_gnt_idx];
            r_grant_id <= w_gnt_idx;
            r_last     <= w_gnt_idx;
            r_busy     <= 1'b1;
          end
        end
        LOAD: begin
          r_state    <= START;
          r_tx_start <= 1'b1;
        end
        START: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.tx_done) begin
            if (GAP_CYCLES > 0) begin
              r_state   <= GAP;
              r_gap_cnt <= GAP_LOAD;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a 4-cycle-gap instance and a
// zero-gap instance, expected grants queued up front and checked at tx_load.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 4;
  localparam int IW  = $clog2(N);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();
  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus0 ();

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bytes(input logic [7:0] base);
    for (int i = 0; i < N; i++) begin
      bus.req_data[i*DW +: DW]  = base + 8'(i);
      bus0.req_data[i*DW +: DW] = base + 8'(i);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.req_valid = '0;  bus.tx_done = 1'b0;
    bus0.req_valid = '0; bus0.tx_done = 1'b0;
    sb.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_load(output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (bus.tx_load === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
  endtask

  // Called in the LOAD cycle; returns in the first cycle after tx_done.
  task automatic complete_frame();
    step();
    step();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = '0; bus.tx_done = 1'b0;
    bus0.req_valid = '0; bus0.tx_done = 1'b0;
    set_bytes(8'h00);
    step();
    checks++;
    if ({bus.tx_load, bus.tx_start, bus.busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pulses: got load/start/busy=%b expected 000", {bus.tx_load, bus.tx_start, bus.busy});
    end
    checks++;
    if ({bus.tx_data, bus.grant_id, bus.req_ready} !== '0) begin
      failures++;
      $display("FAIL reset_regs: got data=%0h gid=%0d ready=%b expected 0/0/0", bus.tx_data, bus.grant_id, bus.req_ready);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: got ready=%b busy=%b expected 0000/0", bus.req_ready, bus.busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    exp_t e;
    bit to;
    apply_reset();
    set_bytes(8'h00);
    bus.req_data[2*DW +: DW] = 8'hA5;
    bus.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready: got %b expected 0100", bus.req_ready);
    end
    sb.push_back('{2, 8'hA5});
    step();
    bus.req_valid = '0;
    e = sb.pop_front();
    checks++;
    if (bus.tx_load !== 1'b1 || bus.tx_data !== e.data || bus.grant_id !== IW'(e.id) || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL single_load: got load=%b data=%0h gid=%0d busy=%b expected 1/%0h/%0d/1",
               bus.tx_load, bus.tx_data, bus.grant_id, bus.busy, e.data, e.id);
    end
    step();
    checks++;
    if ({bus.tx_load, bus.tx_start} !== 2'b01) begin
      failures++;
      $display("FAIL single_start: got load/start=%b expected 01", {bus.tx_load, bus.tx_start});
    end
    repeat (8) step();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    repeat (3) step();
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1 || bus.tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_gap_end: got ready=%b busy=%b data=%0h expected 0000/1/a5", bus.req_ready, bus.busy, bus.tx_data);
    end
    step();
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_next_accept: got ready=%b expected 0001", bus.req_ready);
    end
    sb.push_back('{0, 8'h00});
    step();
    bus.req_valid = '0;
    wait_load(to);
    e = sb.pop_front();
    checks++;
    if (to || bus.tx_data !== e.data || bus.grant_id !== IW'(e.id)) begin
      failures++;
      $display("FAIL single_second: got timeout=%0d data=%0h gid=%0d expected 0/%0h/%0d", to, bus.tx_data, bus.grant_id, e.data, e.id);
    end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit to;
    apply_reset();
    set_bytes(8'h10);
    for (int k = 0; k < 5; k++) sb.push_back('{k % N, 8'h10 + 8'(k % N)});
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_load(to);
      e = sb.pop_front();
      checks++;
      if (to || bus.grant_id !== IW'(e.id) || bus.tx_data !== e.data) begin
        failures++;
        $display("FAIL rr_grant%0d: got timeout=%0d gid=%0d data=%0h expected 0/%0d/%0h", k, to, bus.grant_id, bus.tx_data, e.id, e.data);
      end
      $display("rr frame %0d gid=%0d data=%0h", k, bus.grant_id, bus.tx_data);
      complete_frame();
    end
    bus.req_valid = '0;
    $display("test_round_robin done");
  endtask

  task automatic test_skip();
    exp_t e;
    bit to;
    apply_reset();
    set_bytes(8'h30);
    bus.req_valid = 4'b0010;
    sb.push_back('{1, 8'h31});
    sb.push_back('{3, 8'h33});
    sb.push_back('{1, 8'h31});
    for (int k = 0; k < 3; k++) begin
      wait_load(to);
      e = sb.pop_front();
      checks++;
      if (to || bus.grant_id !== IW'(e.id) || bus.tx_data !== e.data) begin
        failures++;
        $display("FAIL skip_grant%0d: got timeout=%0d gid=%0d data=%0h expected 0/%0d/%0h", k, to, bus.grant_id, bus.tx_data, e.id, e.data);
      end
      bus.req_valid = 4'b1010;
      complete_frame();
    end
    bus.req_valid = '0;
    $display("test_skip done");
  endtask

  task automatic test_spurious_done();
    exp_t e;
    apply_reset();
    set_bytes(8'h50);
    bus.req_valid = 4'b0001;
    bus.tx_done = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL spur_accept: got ready=%b expected 0001", bus.req_ready);
    end
    sb.push_back('{0, 8'h50});
    step();
    bus.req_valid = '0;
    e = sb.pop_front();
    checks++;
    if (bus.tx_load !== 1'b1 || bus.tx_data !== e.data) begin
      failures++;
      $display("FAIL spur_load: got load=%b data=%0h expected 1/%0h", bus.tx_load, bus.tx_data, e.data);
    end
    step();
    checks++;
    if (bus.tx_start !== 1'b1) begin
      failures++;
      $display("FAIL spur_start: got start=%b expected 1", bus.tx_start);
    end
    step();
    bus.tx_done = 1'b0;
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({bus.busy, bus.req_ready, bus.tx_load, bus.tx_start} !== 7'b1000000) begin
        failures++;
        $display("FAIL spur_wait%0d: got busy/ready/load/start=%b expected 1000000", c, {bus.busy, bus.req_ready, bus.tx_load, bus.tx_start});
      end
      step();
    end
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL spur_gap: got ready=%b busy=%b expected 0000/1", bus.req_ready, bus.busy);
    end
    step();
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL spur_reaccept: got ready=%b expected 0010", bus.req_ready);
    end
    sb.push_back('{1, 8'h51});
    step();
    bus.req_valid = '0;
    e = sb.pop_front();
    checks++;
    if (bus.tx_load !== 1'b1 || bus.grant_id !== IW'(e.id) || bus.tx_data !== e.data) begin
      failures++;
      $display("FAIL spur_second: got load=%b gid=%0d data=%0h expected 1/%0d/%0h", bus.tx_load, bus.grant_id, bus.tx_data, e.id, e.data);
    end
    $display("test_spurious_done done");
  endtask

  task automatic test_zero_gap();
    exp_t e;
    apply_reset();
    set_bytes(8'h70);
    bus0.req_valid = 4'b0011;
    #1;
    checks++;
    if (bus0.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL zg_first_ready: got %b expected 0001", bus0.req_ready);
    end
    sb.push_back('{0, 8'h70});
    sb.push_back('{1, 8'h71});
    step();
    e = sb.pop_front();
    checks++;
    if (bus0.tx_load !== 1'b1 || bus0.grant_id !== IW'(e.id) || bus0.tx_data !== e.data) begin
      failures++;
      $display("FAIL zg_first_load: got load=%b gid=%0d data=%0h expected 1/%0d/%0h", bus0.tx_load, bus0.grant_id, bus0.tx_data, e.id, e.data);
    end
    step();
    step();
    bus0.tx_done = 1'b1;
    #1;
    checks++;
    if (bus0.req_ready !== 4'b0000 || bus0.busy !== 1'b1) begin
      failures++;
      $display("FAIL zg_done_cycle: got ready=%b busy=%b expected 0000/1", bus0.req_ready, bus0.busy);
    end
    step();
    bus0.tx_done = 1'b0;
    #1;
    checks++;
    if (bus0.req_ready !== 4'b0010 || bus0.busy !== 1'b0) begin
      failures++;
      $display("FAIL zg_reaccept: got ready=%b busy=%b expected 0010/0", bus0.req_ready, bus0.busy);
    end
    step();
    bus0.req_valid = '0;
    e = sb.pop_front();
    checks++;
    if (bus0.tx_load !== 1'b1 || bus0.grant_id !== IW'(e.id) || bus0.tx_data !== e.data) begin
      failures++;
      $display("FAIL zg_second_load: got load=%b gid=%0d data=%0h expected 1/%0d/%0h", bus0.tx_load, bus0.grant_id, bus0.tx_data, e.id, e.data);
    end
    $display("test_zero_gap done");
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit to;
    apply_reset();
    set_bytes(8'h90);
    bus.req_valid = 4'b0100;
    sb.push_back('{2, 8'h92});
    wait_load(to);
    e = sb.pop_front();
    checks++;
    if (to || bus.grant_id !== IW'(e.id) || bus.tx_data !== e.data) begin
      failures++;
      $display("FAIL rm_setup: got timeout=%0d gid=%0d data=%0h expected 0/%0d/%0h", to, bus.grant_id, bus.tx_data, e.id, e.data);
    end
    bus.req_valid = 4'b1111;
    step();
    step();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.tx_load, bus.tx_start, bus.busy, bus.tx_data, bus.grant_id, bus.req_ready} !== '0) begin
      failures++;
      $display("FAIL rm_wait_reset: got load=%b start=%b busy=%b data=%0h gid=%0d ready=%b expected all 0",
               bus.tx_load, bus.tx_start, bus.busy, bus.tx_data, bus.grant_id, bus.req_ready);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rm_wait_regrant: got ready=%b expected 0001", bus.req_ready);
    end
    sb.push_back('{0, 8'h90});
    step();
    e = sb.pop_front();
    checks++;
    if (bus.tx_load !== 1'b1 || bus.grant_id !== IW'(e.id) || bus.tx_data !== e.data) begin
      failures++;
      $display("FAIL rm_wait_load: got load=%b gid=%0d data=%0h expected 1/%0d/%0h", bus.tx_load, bus.grant_id, bus.tx_data, e.id, e.data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.tx_load, bus.busy, bus.tx_data, bus.grant_id} !== '0) begin
      failures++;
      $display("FAIL rm_load_reset: got load=%b busy=%b data=%0h gid=%0d expected all 0", bus.tx_load, bus.busy, bus.tx_data, bus.grant_id);
    end
    step();
    checks++;
    if (bus.tx_start !== 1'b0) begin
      failures++;
      $display("FAIL rm_no_start: got start=%b expected 0", bus.tx_start);
    end
    reset = 1'b0;
    sb.push_back('{0, 8'h90});
    step();
    e = sb.pop_front();
    checks++;
    if (bus.tx_load !== 1'b1 || bus.tx_start !== 1'b0 || bus.grant_id !== IW'(e.id) || bus.tx_data !== e.data) begin
      failures++;
      $display("FAIL rm_after_release: got load=%b start=%b gid=%0d data=%0h expected 1/0/%0d/%0h",
               bus.tx_load, bus.tx_start, bus.grant_id, bus.tx_data, e.id, e.data);
    end
    bus.req_valid = '0;
    $display("test_reset_mid done");
  endtask

  initial begin
    bus.req_valid = '0;  bus.req_data = '0;  bus.tx_done = 1'b0;
    bus0.req_valid = '0; bus0.req_data = '0; bus0.tx_done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_spurious_done();
    test_zero_gap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between `N_REQ` byte producers. Round-robin arbitration selects a requester and sequences the transmitter's load/start/done handshake. The block sits between the producer-side logic and the UART TX control path, which loads on `tx_load` and starts shifting on `tx_start`. An optional inter-frame gap holds the line idle between consecutive frames.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2 to 8.
- `DATA_W`, 8: byte width.
- `GAP_CYCLES`, 16: idle clock cycles inserted after each frame. A value of 0 disables the gap.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  N_REQ: requester i holds a byte.
- `req_data`  in  N_REQ*DATA_W: byte of requester i at bits [i*DATA_W +: DATA_W].
- `req_ready`  out  N_REQ: one-hot accept. A transfer happens when `req_valid[i] & req_ready[i]`.
- `tx_load`  out  1: one-cycle pulse that loads `tx_data` into the transmitter.
- `tx_data`  out  DATA_W: latched byte. Stable from the LOAD cycle until the next accept.
- `tx_start`  out  1: one-cycle pulse that starts the frame.
- `tx_done`  in  1: one-cycle pulse from the transmitter at stop-bit end.
- `grant_id`  out  $clog2(N_REQ): index of the requester being served.
- `busy`  out  1: high in every state except IDLE.

## Operation
State machine: IDLE, LOAD, START, WAIT, GAP.
- **IDLE**
  - If any `req_valid` is high, the winner is the first valid index searching upward from `last_grant+1` (mod N_REQ).
  - `req_ready[winner]=1` combinationally in the same cycle.
  - On that edge: latch `tx_data`, set `grant_id` and `last_grant` to the winner, and go to LOAD.
  - If no `req_valid` is high, `req_ready` is all zeros and the block stays in IDLE.
- **LOAD**: `tx_load=1`, then go to START.
- **START**: `tx_start=1`, then go to WAIT.
- **WAIT**: stay until `tx_done=1`, then go to GAP if `GAP_CYCLES>0`, else to IDLE.
- **GAP**: the gap counter loads `GAP_CYCLES-1` on entry and decrements each cycle. Exit to IDLE on the cycle it reads 0.
- `tx_done` is ignored outside WAIT. A `tx_done` in the START cycle is not sampled.
- `req_ready` is 0 outside IDLE. `req_valid` may change freely while not granted.
- A requester dropping `req_valid` before its grant loses nothing. Arbitration is re-evaluated every IDLE cycle.
- Gap counter width is `$clog2(GAP_CYCLES+1)`. It never wraps: it is loaded on GAP entry only.

## Timing
- Reset values: state IDLE, `last_grant=N_REQ-1` (so requester 0 has first priority), `tx_load=0`, `tx_start=0`, `tx_data=0`, `grant_id=0`, `busy=0`, gap counter 0. `req_ready=0` while no `req_valid` is asserted.
- Accept in cycle T gives `tx_load` at T+1, `tx_start` at T+2, and WAIT from T+3.
- `tx_done` at cycle D gives GAP during D+1 to D+GAP_CYCLES, and IDLE (next accept possible) at D+GAP_CYCLES+1. With `GAP_CYCLES=0`, IDLE is at D+1.
- `tx_load` and `tx_start` are registered state decodes: glitch-free, exactly one cycle each per frame.
- Reset asserted in any state returns every register to its reset value immediately. The in-flight grant is abandoned, and no `tx_start` issues after reset if it had not already issued.

## Structure
- Package `uart_arb_pkg`: state enum `arb_state_e` (IDLE, LOAD, START, WAIT, GAP) and default-parameter constants.
- Sub-module `rr_arbiter`: combinational rotating-priority picker.
  - Inputs: `req`[N], `last`.
  - Outputs: `gnt_onehot`[N], `gnt_idx`, `any`.
- The top level holds the FSM, the data/grant registers and the gap counter.

## Test plan
- Single requester: reset, `req_valid[2]=1`, `data=8'hA5` at T. Expect `req_ready[2]` at T, `tx_load` at T+1 with `tx_data=A5`, `tx_start` at T+2. With `tx_done` at T+10 and `GAP_CYCLES=4`, the next accept is possible at T+15.
- Round-robin fairness: all four `req_valid` held high. Grants follow the order 0,1,2,3,0. No requester is served twice before every other valid requester is served once.
- Skip idle requesters: only requesters 1 and 3 valid, `last_grant=1`. Grant 3, then 1.
- Spurious `tx_done`: pulse `tx_done` in IDLE, LOAD and START. The FSM is unaffected and waits in WAIT for the real pulse.
- Zero gap: `GAP_CYCLES=0`, two requesters valid. The second accept occurs exactly one cycle after `tx_done`.
- Reset mid-frame: assert `reset` in WAIT and in LOAD. All outputs go to reset values in the same cycle, and the first grant after release goes to requester 0.
